apb_follower_regbank: RTL and testbench
=======================================

Name: apb_follower_regbank

Overview:
- APB completer (follower) answering one PSEL line driven by the team's single-requester APB leader.
- Contains a word-addressed register bank with a configurable number of wait states.
- Register 0 is a read-only ID register; out-of-range or illegal accesses return PSLVERR.
- Two instances sit behind the leader: one on PSEL[0], one on PSEL[1]. Address MSB selects the follower and is ignored inside the block.

Parameters:
- ADDR_WIDTH, 10, PADDR width. PADDR[ADDR_WIDTH-1] is the follower-select bit and is ignored; the register index is PADDR[ADDR_WIDTH-2:0].
- DATA_WIDTH, 16, PWDATA/PRDATA width and register width.
- NUM_REGS, 16, number of registers, including ID register 0. Legal range 2..2^(ADDR_WIDTH-1).
- WAIT_CYCLES, 2, number of ACCESS cycles with PREADY=0 before completion. 0 gives zero-wait transfers.
- ID_VALUE, 16'hA5B0, constant returned by register 0.

Ports:
- PCLK, input, 1, single clock; all logic is on its rising edge.
- PRESET, input, 1, reset; synchronous, active-high.
- PSEL, input, 1, follower select (one bit of the leader's PSEL bus).
- PENABLE, input, 1, APB access-phase indicator.
- PWRITE, input, 1, 1=write, 0=read.
- PADDR, input, ADDR_WIDTH, transfer address.
- PWDATA, input, DATA_WIDTH, write data.
- PREADY, output, 1, transfer completion.
- PRDATA, output, DATA_WIDTH, read data; valid only while PREADY=1.
- PSLVERR, output, 1, error response; valid only while PREADY=1.
- reg_wr_strobe, output, 1, one-cycle pulse when a register write commits.
- reg_wr_idx, output, ADDR_WIDTH-1, index of the committed write; valid with reg_wr_strobe.

Behaviour:
- Reset (PRESET=1 at a PCLK edge):
  - State goes to IDLE.
  - Registers 1..NUM_REGS-1 clear to 0; wait counter clears to 0.
  - Outputs after reset: PREADY=0, PRDATA=0, PSLVERR=0, reg_wr_strobe=0, reg_wr_idx=0.
  - Reset asserted mid-transfer aborts the transfer with no write commit. The requester's transfer never completes.
- FSM has two states, IDLE and ACCESS:
  - IDLE -> ACCESS when PSEL=1 and PENABLE=0 (bus SETUP phase). On that edge the block latches addr_q=PADDR[ADDR_WIDTH-2:0], wr_q=PWRITE, wdata_q=PWDATA, and loads cnt=WAIT_CYCLES.
  - In IDLE, PSEL=1 with PENABLE=1 is ignored (no SETUP was seen).
  - ACCESS with PSEL=1 and PENABLE=1:
    - If cnt!=0: PREADY=0 and cnt decrements.
    - If cnt==0: PREADY=1, and the next state is IDLE.
  - ACCESS with PSEL=0 or PENABLE=0: protocol abort. Next state is IDLE, no commit, no PREADY.
  - Back-to-back transfers: the leader presents the next SETUP in the cycle after completion. IDLE detects it, so there is no dead cycle beyond APB's mandatory SETUP.
- Latency: total transfer is 2+WAIT_CYCLES bus cycles (SETUP + ACCESS). PREADY is high for exactly one cycle per completed transfer.
- PREADY, PRDATA and PSLVERR are combinational from the state, cnt and latched fields. They do not depend on the live PADDR/PWDATA.
- Error decode (err = addr_q >= NUM_REGS, or (wr_q=1 and addr_q==0)):
  - err=1: PSLVERR=1 in the PREADY cycle, PRDATA=0, no write.
  - err=0: PSLVERR=0.
- Read, err=0: PRDATA = (addr_q==0) ? ID_VALUE : reg[addr_q] during the PREADY cycle. PRDATA=0 in every other cycle.
- Write, err=0: reg[addr_q] <= wdata_q on the edge ending the PREADY cycle. reg_wr_strobe=1 and reg_wr_idx=addr_q in the cycle after that edge.
- Read-after-write to the same register in the next transfer returns the new value.
- PWDATA changing during ACCESS has no effect, because wdata_q was latched in SETUP.

Test Plan:
- Reset, then read idx 0 (PADDR=10'h000) → PREADY after 2 wait cycles, PRDATA=16'hA5B0, PSLVERR=0.
- Write 16'h1234 to PADDR=10'h205 (MSB set; index 5), then read idx 5 → read returns 16'h1234; reg_wr_strobe pulses once with reg_wr_idx=5.
- Write 16'hFFFF to idx 0 → PSLVERR=1 with PREADY; a following read of idx 0 still returns 16'hA5B0; no reg_wr_strobe.
- Read idx 20 with NUM_REGS=16 → PSLVERR=1, PRDATA=0. Rerun with WAIT_CYCLES=0 → PREADY in the first ACCESS cycle; 5 back-to-back writes each take exactly 2 cycles.
- Write 16'h00AA to idx 3, assert PRESET during the wait cycles, release, then read idx 3 → 16'h0000, no PREADY for the aborted transfer, all outputs 0 during reset.
- Drop PENABLE in the middle of ACCESS while writing idx 2 → FSM returns to IDLE, no commit; a following read of idx 2 returns 0.

Source files
------------

// File: rtl/apb_follower_regbank.sv
`default_nettype none
// ============================================================================
// Module      : apb_follower_regbank
// Description : APB completer with a word-addressed register bank. Register 0
//               is a read-only ID. Each transfer inserts a fixed number of wait
//               states. Out-of-range indices and writes to the ID register
//               return PSLVERR. The address MSB selects between two followers
//               behind the same leader, so it is not decoded here.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_follower_regbank #(
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 16'hA5B0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    output logic                  reg_wr_strobe,
    output logic [ADDR_WIDTH-2:0] reg_wr_idx
);

    localparam int IDX_W = ADDR_WIDTH - 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] c_WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    // One bit wider than the index so NUM_REGS == 2^IDX_W still fits
    localparam logic [IDX_W:0]   c_NUM_REGS  = (IDX_W + 1)'(NUM_REGS);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        addr_q, addr_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   regs_q [1:NUM_REGS-1];
    logic                    wr_strobe_q;
    logic [IDX_W-1:0]        wr_idx_q;

    logic                    w_done;
    logic                    w_err;
    logic                    w_commit;
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic                    w_unused_sel;

    // Follower-select bit is consumed by the leader's decode, not here
    assign w_unused_sel = PADDR[ADDR_WIDTH-1];

    // Decode of the latched transfer: error and the completion cycle.
    // Completion is masked while reset is asserted so an aborted transfer
    // never shows PREADY.
    assign w_err    = ({1'b0, addr_q} >= c_NUM_REGS) || (wr_q && (addr_q == '0));
    assign w_done   = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == '0) && !PRESET;
    assign w_commit = w_done && wr_q && !w_err;

    // Read mux over the ID constant and the storage registers
    always_comb begin
        w_rd_word = '0;
        if (addr_q == '0) begin
            w_rd_word = ID_VALUE;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (addr_q == IDX_W'(i)) begin
                w_rd_word = regs_q[i];
            end
        end
    end

    // FSM state and latched transfer fields
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic and response outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        PREADY  = w_done;
        PSLVERR = w_done && w_err;
        PRDATA  = (w_done && !wr_q && !w_err) ? w_rd_word : '0;

        case (state_q)
            IDLE: begin
                // SETUP phase: capture everything so later bus changes are ignored
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    addr_d  = PADDR[IDX_W-1:0];
                    wr_d    = PWRITE;
                    wdata_d = PWDATA;
                    cnt_d   = c_WAIT_LOAD;
                end
            end
            ACCESS: begin
                if (!(PSEL && PENABLE)) begin
                    // Requester left the access phase early: drop the transfer
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register storage; the write lands on the edge closing the PREADY cycle
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (addr_q == IDX_W'(i)) begin
                    regs_q[i] <= wdata_q;
                end
            end
        end
    end

    // Write-commit notification, visible the cycle after the commit edge
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_strobe_q <= 1'b0;
            wr_idx_q    <= '0;
        end else begin
            wr_strobe_q <= w_commit;
            if (w_commit) begin
                wr_idx_q <= addr_q;
            end
        end
    end

    assign reg_wr_strobe = wr_strobe_q;
    assign reg_wr_idx    = wr_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_follower_regbank.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_follower_regbank
// Description : Self-checking bench for two followers, one with two wait
//               states and one zero-wait. A scoreboard queue holds expected
//               responses pushed when a transfer is issued and popped when
//               PREADY is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_follower_regbank;

    typedef struct {
        int          u;
        bit          w;
        bit          err;
        logic [15:0] data;
        int          idx;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [9:0]  paddr   [2];
    logic [15:0] pwdata  [2];
    logic        pready  [2];
    logic [15:0] prdata  [2];
    logic        pslverr [2];
    logic        strobe  [2];
    logic [8:0]  wr_idx  [2];

    logic [15:0] mem [2][16];
    sb_t         sbq [$];
    int          checks;
    int          errors;
    int          cyc;
    bit          exp_strb_v   [2];
    int          exp_strb_idx [2];
    int          exp_strb_cyc [2];

    apb_follower_regbank #(.WAIT_CYCLES(2)) u_dut_w2 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]),
        .reg_wr_strobe(strobe[0]), .reg_wr_idx(wr_idx[0])
    );

    apb_follower_regbank #(.WAIT_CYCLES(0)) u_dut_w0 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]),
        .reg_wr_strobe(strobe[1]), .reg_wr_idx(wr_idx[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int wait_of(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    // Response and write-strobe monitor
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            bit due;
            sb_t e;
            due = exp_strb_v[u] && (exp_strb_cyc[u] == cyc);
            if (strobe[u] || due) begin
                check("wr_strobe", {31'd0, strobe[u]}, {31'd0, due});
                if (due) check("wr_idx", {23'd0, wr_idx[u]}, exp_strb_idx[u]);
            end
            if (due) exp_strb_v[u] = 1'b0;
            if (pready[u]) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("ready_unit", u, e.u);
                    check("pslverr", {31'd0, pslverr[u]}, {31'd0, e.err});
                    check("prdata", {16'd0, prdata[u]}, {16'd0, e.data});
                    if (e.w && !e.err) begin
                        exp_strb_v[u]   = 1'b1;
                        exp_strb_idx[u] = e.idx;
                        exp_strb_cyc[u] = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic bus_idle(input int u);
        @(posedge clk); #1;
        psel[u] = 1'b0; penable[u] = 1'b0;
    endtask

    task automatic xfer(input int u, input bit w, input logic [9:0] a, input logic [15:0] d);
        sb_t e;
        int  idx;
        int  start;
        bit  done;
        idx   = int'(a[8:0]);
        e.u   = u;
        e.w   = w;
        e.idx = idx;
        e.err = (idx >= 16) || (w && idx == 0);
        e.data = 16'h0000;
        if (!w && !e.err) e.data = (idx == 0) ? 16'hA5B0 : mem[u][idx];
        if (w && !e.err) mem[u][idx] = d;
        sbq.push_back(e);
        @(posedge clk); #1;
        psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = w; paddr[u] = a; pwdata[u] = d;
        start = cyc;
        @(posedge clk); #1;
        penable[u] = 1'b1;
        pwdata[u]  = ~d;  // must be ignored: data was captured in SETUP
        paddr[u]   = ~a;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (pready[u]) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("ready_timeout", {31'd0, done}, 32'd1);
        if (done) check("latency", cyc - start, 1 + wait_of(u));
    endtask

    task automatic check_quiet(input int u, input string tag);
        check(tag, {15'd0, pready[u], prdata[u]}, 32'd0);
        check(tag, {30'd0, pslverr[u], strobe[u]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            psel[u] = 0; penable[u] = 0; pwrite[u] = 0; paddr[u] = '0; pwdata[u] = '0;
            exp_strb_v[u] = 0; exp_strb_idx[u] = 0; exp_strb_cyc[u] = 0;
            for (int r = 0; r < 16; r++) mem[u][r] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check_quiet(u, "reset_outputs");
            check("reset_wr_idx", {23'd0, wr_idx[u]}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Two-wait follower: ID read, write/readback, ID write error, range errors
        xfer(0, 0, 10'h000, 16'h0000);
        xfer(0, 1, 10'h205, 16'h1234);
        xfer(0, 0, 10'h005, 16'h0000);
        xfer(0, 1, 10'h000, 16'hFFFF);
        xfer(0, 0, 10'h000, 16'h0000);
        xfer(0, 0, 10'h014, 16'h0000);
        xfer(0, 1, 10'h00F, 16'hBEEF);
        xfer(0, 0, 10'h20F, 16'h0000);
        xfer(0, 0, 10'h010, 16'h0000);
        xfer(0, 1, 10'h010, 16'h7777);
        bus_idle(0);
        repeat (2) @(posedge clk);

        // Requester drops PENABLE mid-ACCESS: no commit, no response
        @(posedge clk); #1;
        psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 10'h002; pwdata[0] = 16'h5555;
        @(posedge clk); #1;
        penable[0] = 1;
        @(negedge clk);
        check_quiet(0, "abort_wait");
        @(posedge clk); #1;
        penable[0] = 0;
        @(negedge clk);
        check_quiet(0, "abort_drop");
        bus_idle(0);
        @(negedge clk);
        check_quiet(0, "abort_after");
        xfer(0, 0, 10'h002, 16'h0000);
        bus_idle(0);

        // Zero-wait follower: error read, five back-to-back writes, readback
        xfer(1, 0, 10'h214, 16'h0000);
        for (int i = 1; i <= 5; i++) xfer(1, 1, 10'(i), 16'(16'h1100 + i * 16'h0101));
        for (int i = 1; i <= 5; i++) xfer(1, 0, 10'(10'h200 + i), 16'h0000);
        bus_idle(1);

        // Reset during the wait states of a write to idx 3
        @(posedge clk); #1;
        psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 10'h003; pwdata[0] = 16'h00AA;
        @(posedge clk); #1;
        penable[0] = 1;
        @(negedge clk);
        check_quiet(0, "rst_wait");
        @(posedge clk); #1;
        rst = 1'b1; psel[0] = 0; penable[0] = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check_quiet(0, "during_reset");
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int u = 0; u < 2; u++) for (int r = 0; r < 16; r++) mem[u][r] = 16'h0000;
        xfer(0, 0, 10'h003, 16'h0000);
        xfer(0, 0, 10'h005, 16'h0000);
        bus_idle(0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", sbq.size(), 32'd0);
        check("strobe_pending", {30'd0, exp_strb_v[1], exp_strb_v[0]}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
